// File: rtl/load_seq_pkg.sv
// Shared types and default sizing for the CPU load/run sequencer.
package load_seq_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CYC_W  = 16;
    localparam int MEM_DEPTH      = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_I = 3'd1,
        ST_LOAD_D = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/load_word_counter.sv
// Up-counter with clear, load and increment, plus an equality compare against a terminal value.
// Latency: count updates on the clock edge after clr/ld/inc; at_term is combinational from the count.
// Backpressure: none; the owner decides when to increment.
module load_word_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/load_sequencer.sv
// Boot/run sequencer: streams host words into imem then dmem under CPU reset, then runs the CPU for run_cycles.
// Latency: write strobes, cpu_rst and done are registered one cycle after the handshake / state decision.
// Backpressure: s_ready decodes from state only; host may stall freely. LOAD_SEQ_CHECKSUM_EN adds an XOR trailer check.
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CYC_W  = DEFAULT_CYC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   imem_count,
    input  logic [ADDR_W:0]   dmem_count,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              imem_we,
    output logic              dmem_we,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = ADDR_W + 1;

`ifdef LOAD_SEQ_CHECKSUM_EN
    localparam seq_state_e POST_LOAD = ST_CHECK;
`else
    localparam seq_state_e POST_LOAD = ST_RUN;
`endif

    seq_state_e state_q, state_d;

    logic [CW-1:0]    imem_cnt_q, dmem_cnt_q;
    logic [CYC_W-1:0] run_cyc_q;

    logic [CW-1:0]    word_cnt, word_term;
    logic             word_at_term, word_clr, word_inc;
    logic [CYC_W-1:0] cyc_cnt, cyc_term;
    logic             cyc_at_term, cyc_clr, cyc_inc;

    logic hs, start_go, abort_go, wr_i, wr_d;

    assign busy    = (state_q != ST_IDLE);
    assign s_ready = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D) || (state_q == ST_CHECK);

    assign hs       = s_valid && s_ready;
    assign start_go = (state_q == ST_IDLE) && start;
    assign abort_go = (state_q != ST_IDLE) && abort;

    // A handshake coinciding with abort is dropped: abort wins over the write.
    assign wr_i = (state_q == ST_LOAD_I) && hs && !abort;
    assign wr_d = (state_q == ST_LOAD_D) && hs && !abort;

    assign word_term = (state_q == ST_LOAD_D) ? (dmem_cnt_q - CW'(1)) : (imem_cnt_q - CW'(1));
    assign cyc_term  = run_cyc_q - CYC_W'(1);
    assign cyc_clr   = (state_q != ST_RUN);
    assign cyc_inc   = (state_q == ST_RUN);

    load_word_counter #(.W(CW)) u_word_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (word_clr),
        .ld      (1'b0),
        .ld_val  ('0),
        .inc     (word_inc),
        .term    (word_term),
        .cnt     (word_cnt),
        .at_term (word_at_term)
    );

    load_word_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cyc_clr),
        .ld      (1'b0),
        .ld_val  ('0),
        .inc     (cyc_inc),
        .term    (cyc_term),
        .cnt     (cyc_cnt),
        .at_term (cyc_at_term)
    );

`ifdef LOAD_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] xor_q;
    logic              err_q;
    logic              chk_match;

    assign chk_match = (s_data == xor_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xor_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_go) begin
                xor_q <= '0;
                err_q <= 1'b0;
            end else if (wr_i || wr_d) begin
                xor_q <= xor_q ^ s_data;
            end
            if ((state_q == ST_CHECK) && hs && !abort && !chk_match) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        word_clr = 1'b0;
        word_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    word_clr = 1'b1;
                    if (imem_count != '0)      state_d = ST_LOAD_I;
                    else if (dmem_count != '0) state_d = ST_LOAD_D;
                    else                       state_d = POST_LOAD;
                end
            end
            ST_LOAD_I: begin
                if (hs) begin
                    if (word_at_term) begin
                        word_clr = 1'b1;
                        state_d  = (dmem_cnt_q != '0) ? ST_LOAD_D : POST_LOAD;
                    end else begin
                        word_inc = 1'b1;
                    end
                end
            end
            ST_LOAD_D: begin
                if (hs) begin
                    if (word_at_term) begin
                        word_clr = 1'b1;
                        state_d  = POST_LOAD;
                    end else begin
                        word_inc = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
`ifdef LOAD_SEQ_CHECKSUM_EN
                if (hs) state_d = chk_match ? ST_RUN : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RUN: begin
                // run_cycles == 0 runs until abort.
                if ((run_cyc_q != '0) && cyc_at_term) state_d = ST_HALT;
            end
            ST_HALT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_go) begin
            state_d  = ST_IDLE;
            word_clr = 1'b1;
            word_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            imem_cnt_q <= '0;
            dmem_cnt_q <= '0;
            run_cyc_q  <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                imem_cnt_q <= imem_count;
                dmem_cnt_q <= dmem_count;
                run_cyc_q  <= run_cycles;
            end
            imem_we <= wr_i;
            dmem_we <= wr_d;
            if (wr_i || wr_d) begin
                mem_addr <= word_cnt[ADDR_W-1:0];
                mem_data <= s_data;
            end
            cpu_rst <= (state_d != ST_RUN);
            done    <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: table vectors, hand-written corner sequences and randomized runs vs a write-list model.
module tb_load_sequencer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CYC_W  = 16;

    logic              clk, rst, start, abort;
    logic [ADDR_W:0]   imem_count, dmem_count;
    logic [CYC_W-1:0]  run_cycles;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] s_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              imem_we, dmem_we, cpu_rst, busy, done, err;

    load_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .imem_count(imem_count), .dmem_count(dmem_count), .run_cycles(run_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .imem_we(imem_we), .dmem_we(dmem_we),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              is_d;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int icnt; int dcnt; int rc; int mode;
        int exp_wr; int exp_low; int exp_done;
    } vec_t;

    // Monitor: running totals only; tests snapshot bases and compare deltas.
    wr_t wr_log[$];
    int  rst_low_tot = 0;
    int  done_tot = 0;
    int  wr_base, rst_base, done_base;
    int  n_chk = 0;
    int  n_pass = 0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_log.push_back({1'b0, mem_addr, mem_data});
        if (dmem_we === 1'b1) wr_log.push_back({1'b1, mem_addr, mem_data});
        if (cpu_rst === 1'b0) rst_low_tot++;
        if (done === 1'b1)    done_tot++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1);
    end

    localparam logic [63:0] RST_VEC = 64'({3'b000, 10'd0, 32'd0, 4'b1000});

    function automatic logic [63:0] outs();
        return 64'({s_ready, imem_we, dmem_we, mem_addr, mem_data, cpu_rst, busy, done, err});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic mark();
        wr_base   = wr_log.size();
        rst_base  = rst_low_tot;
        done_base = done_tot;
    endtask

    task automatic check_writes(input string name, input wr_t eq[$]);
        int bad = 0;
        chk({name, "_wr_count"}, 64'(wr_log.size() - wr_base), 64'(eq.size()));
        for (int i = 0; i < eq.size(); i++)
            if (wr_base + i >= wr_log.size() || wr_log[wr_base + i] !== eq[i]) bad++;
        chk({name, "_wr_content"}, 64'(bad), 64'd0);
    endtask

    task automatic do_start(input int icnt, input int dcnt, input int rc);
        imem_count = (ADDR_W+1)'(icnt);
        dmem_count = (ADDR_W+1)'(dcnt);
        run_cycles = CYC_W'(rc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: toggled every other cycle, 2: random.
    task automatic stream(input logic [31:0] w[$], input int mode, output bit ok, output int cyc);
        int idx = 0;
        bit tog = 1'b0;
        bit v;
        cyc = 0;
        while (idx < w.size() && cyc < 8 * w.size() + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = tog;
                default: v = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            s_valid = v;
            s_data  = v ? w[idx] : $urandom();
            if (v && s_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        ok = (idx == w.size());
    endtask

    task automatic run_seq(input string name, input int icnt, input int dcnt, input int rc, input int mode,
                           input logic [31:0] w[$], input int exp_wr, input int exp_low, input int exp_done);
        logic [31:0] sq[$];
        wr_t eq[$];
        bit ok;
        int cyc;
        sq = w;
`ifdef LOAD_SEQ_CHECKSUM_EN
        begin
            logic [31:0] x;
            x = '0;
            foreach (w[i]) x ^= w[i];
            sq.push_back(x);
        end
`endif
        for (int i = 0; i < icnt; i++) eq.push_back({1'b0, ADDR_W'(i), w[i]});
        for (int j = 0; j < dcnt; j++) eq.push_back({1'b1, ADDR_W'(j), w[icnt + j]});
        mark();
        do_start(icnt, dcnt, rc);
        stream(sq, mode, ok, cyc);
        chk({name, "_stream_done"}, 64'(ok), 64'd1);
        if (mode == 0) chk({name, "_one_word_per_cycle"}, 64'(cyc), 64'(sq.size()));
        for (int c = 0; c < rc + 10 && done_tot == done_base; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk({name, "_wr_total"}, 64'(wr_log.size() - wr_base), 64'(exp_wr));
        check_writes(name, eq);
        chk({name, "_cpu_rst_low_cycles"}, 64'(rst_low_tot - rst_base), 64'(exp_low));
        chk({name, "_done_pulses"}, 64'(done_tot - done_base), 64'(exp_done));
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    vec_t        vecs[6];
    logic [31:0] spec_words[$];
    logic [31:0] w[$];
    bit          ok;
    int          cyc;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        imem_count = '0; dmem_count = '0; run_cycles = '0;
        spec_words = '{32'h04010005, 32'h04020007, 32'h00221800, 32'h0000002A};

        vecs[0] = '{icnt: 3,    dcnt: 1, rc: 4, mode: 0, exp_wr: 4,    exp_low: 4, exp_done: 1};
        vecs[1] = '{icnt: 3,    dcnt: 1, rc: 4, mode: 1, exp_wr: 4,    exp_low: 4, exp_done: 1};
        vecs[2] = '{icnt: 0,    dcnt: 0, rc: 1, mode: 0, exp_wr: 0,    exp_low: 1, exp_done: 1};
        vecs[3] = '{icnt: 0,    dcnt: 2, rc: 3, mode: 2, exp_wr: 2,    exp_low: 3, exp_done: 1};
        vecs[4] = '{icnt: 5,    dcnt: 0, rc: 2, mode: 1, exp_wr: 5,    exp_low: 2, exp_done: 1};
        vecs[5] = '{icnt: 1024, dcnt: 2, rc: 3, mode: 0, exp_wr: 1026, exp_low: 3, exp_done: 1};

        #2 rst = 1'b0;
        #2 chk("reset_outputs", outs(), RST_VEC);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        chk("reset_released_outputs", outs(), RST_VEC);

        foreach (vecs[i]) begin
            if (i < 2) begin
                w = spec_words;
            end else begin
                w.delete();
                for (int k = 0; k < vecs[i].icnt + vecs[i].dcnt; k++) w.push_back($urandom());
            end
            run_seq($sformatf("vec%0d", i), vecs[i].icnt, vecs[i].dcnt, vecs[i].rc, vecs[i].mode,
                    w, vecs[i].exp_wr, vecs[i].exp_low, vecs[i].exp_done);
        end

        // Empty load: straight to RUN (or CHECK first), one run cycle, then done.
        mark();
        do_start(0, 0, 1);
`ifdef LOAD_SEQ_CHECKSUM_EN
        chk("zero_check_ready", 64'(s_ready), 64'd1);
        chk("zero_check_rst", 64'(cpu_rst), 64'd1);
        s_valid = 1'b1; s_data = '0;
        @(posedge clk); #1;
        s_valid = 1'b0;
`endif
        chk("zero_run_rst", 64'(cpu_rst), 64'd0);
        chk("zero_run_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("zero_halt_done", 64'(done), 64'd1);
        chk("zero_halt_rst", 64'(cpu_rst), 64'd1);
        @(posedge clk); #1;
        chk("zero_idle_busy", 64'(busy), 64'd0);
        chk("zero_idle_done", 64'(done), 64'd0);

        // Abort after the 2nd instruction word, with a 3rd word offered alongside abort.
        mark();
        do_start(3, 1, 4);
        s_valid = 1'b1; s_data = spec_words[0];
        @(posedge clk); #1;
        s_data = spec_words[1];
        @(posedge clk); #1;
        s_data = spec_words[2]; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_busy_next", 64'(busy), 64'd0);
        chk("abort_ready_next", 64'(s_ready), 64'd0);
        repeat (8) begin @(posedge clk); #1; end
        check_writes("abort", '{{1'b0, 10'd0, spec_words[0]}, {1'b0, 10'd1, spec_words[1]}});
        chk("abort_no_done", 64'(done_tot - done_base), 64'd0);
        chk("abort_cpu_rst_held", 64'(rst_low_tot - rst_base), 64'd0);
        run_seq("reload", 3, 1, 4, 0, spec_words, 4, 4, 1);

        for (int it = 0; it < 6; it++) begin
            int ic, dc, rc;
            ic = $urandom_range(0, 6);
            dc = $urandom_range(0, 6);
            rc = $urandom_range(1, 8);
            w.delete();
            for (int k = 0; k < ic + dc; k++) w.push_back($urandom());
            run_seq($sformatf("rand%0d", it), ic, dc, rc, 2, w, ic + dc, rc, 1);
        end

`ifdef LOAD_SEQ_CHECKSUM_EN
        mark();
        do_start(2, 0, 2);
        stream('{32'h1, 32'h2, 32'h4}, 0, ok, cyc);
        chk("cksum_bad_stream", 64'(ok), 64'd1);
        chk("cksum_bad_err", 64'(err), 64'd1);
        chk("cksum_bad_busy", 64'(busy), 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("cksum_bad_no_run", 64'(rst_low_tot - rst_base), 64'd0);
        chk("cksum_bad_no_done", 64'(done_tot - done_base), 64'd0);
        run_seq("cksum_good", 2, 0, 2, 0, '{32'h1, 32'h2}, 2, 2, 1);
        chk("cksum_good_err", 64'(err), 64'd0);
`endif

        // Long run: start ignored while busy, then async reset mid-RUN.
        do_start(0, 0, 50);
`ifdef LOAD_SEQ_CHECKSUM_EN
        stream('{32'h0}, 0, ok, cyc);
`endif
        repeat (3) begin @(posedge clk); #1; end
        chk("run_cpu_rst_low", 64'(cpu_rst), 64'd0);
        do_start(5, 0, 1);
        chk("start_ignored_busy", 64'(busy), 64'd1);
        chk("start_ignored_cpu_rst", 64'(cpu_rst), 64'd0);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", outs(), RST_VEC);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("after_reset_idle", outs(), RST_VEC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
